// File: rtl/membus_arb_pkg.sv
// Shared types and constants for the two-to-one memory bus arbiter.
package membus_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic GNT_D = 1'b0;
    localparam logic GNT_I = 1'b1;

endpackage

// File: rtl/membus_arbiter.sv
// Fixed-priority (data first) arbiter for the shared downstream memory bus,
// with a starvation counter that forces an instruction grant after MAX_WAIT losses.
module membus_arbiter
    import membus_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_valid,
    output logic              i_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_wen,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_valid,
    output logic              d_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wen,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_wen,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,

    output logic              busy,
    output logic              err_rvalid
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    state_t           state, state_nxt;
    logic             grant, grant_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic             decide;
    logic             any_req;
    logic             win_i;

    assign any_req = i_valid | d_valid;
    // Instruction wins alone, or against data once it has been starved long enough.
    assign win_i   = i_valid && (!d_valid || (starve_cnt == MAX_CNT));

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        starve_nxt = starve_cnt;
        decide     = 1'b0;

        case (state)
            IDLE:    decide = 1'b1;
            REQ:     if (m_ready) state_nxt = RESP;
            RESP:    if (m_rvalid) decide = 1'b1;
            default: state_nxt = IDLE;
        endcase

        if (decide) begin
            if (any_req) begin
                state_nxt = REQ;
                grant_nxt = win_i ? GNT_I : GNT_D;
                if (win_i) begin
                    starve_nxt = '0;
                end else if (i_valid && (starve_cnt != MAX_CNT)) begin
                    starve_nxt = starve_cnt + CNT_W'(1);
                end
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GNT_D;
            starve_cnt <= '0;
            err_rvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            starve_cnt <= starve_nxt;
            // A response with no transaction awaiting it is dropped and flagged.
            if (m_rvalid && (state != RESP)) err_rvalid <= 1'b1;
        end
    end

    assign busy    = (state != IDLE);
    assign m_valid = (state == REQ);
    assign m_addr  = m_valid ? ((grant == GNT_I) ? i_addr  : d_addr)  : '0;
    assign m_wen   = m_valid ? ((grant == GNT_I) ? i_wen   : d_wen)   : 1'b0;
    assign m_wdata = m_valid ? ((grant == GNT_I) ? i_wdata : d_wdata) : '0;

    assign i_ready  = m_valid && (grant == GNT_I) && m_ready;
    assign d_ready  = m_valid && (grant == GNT_D) && m_ready;
    assign i_rvalid = (state == RESP) && (grant == GNT_I) && m_rvalid;
    assign d_rvalid = (state == RESP) && (grant == GNT_D) && m_rvalid;

    // Response data is broadcast; only the strobe identifies the owner.
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed scenarios plus randomized traffic for membus_arbiter, checked every
// cycle against a transaction-level reference model.
module tb_membus_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready, i_wen, i_rvalid;
    logic [31:0] i_addr, i_wdata, i_rdata;
    logic        d_valid, d_ready, d_wen, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_valid, m_ready, m_wen, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        busy, err_rvalid;

    membus_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_wen(i_wen),
        .i_wdata(i_wdata), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
        .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wen(m_wen),
        .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .busy(busy), .err_rvalid(err_rvalid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: is a request on the bus, is one accepted and awaiting
    // its response, who owns it, how many times instruction has lost in a row.
    bit mdl_flight, mdl_await, mdl_who, mdl_err;
    int mdl_loss;

    int n_irv, n_drv;
    bit i_acked, d_acked;
    bit acc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        e_iready, e_dready, e_wen;
        logic [31:0] e_addr, e_wdata;
        bit n_flight, n_await, n_who, n_err, free, iw;
        int n_loss;
        @(negedge clk);
        e_addr   = mdl_flight ? (mdl_who ? i_addr : d_addr) : 32'h0;
        e_wen    = mdl_flight ? (mdl_who ? i_wen : d_wen) : 1'b0;
        e_wdata  = mdl_flight ? (mdl_who ? i_wdata : d_wdata) : 32'h0;
        e_iready = mdl_flight && mdl_who && m_ready;
        e_dready = mdl_flight && !mdl_who && m_ready;
        chk("busy", busy, mdl_flight || mdl_await);
        chk("m_valid", m_valid, mdl_flight);
        chk("m_addr", m_addr, e_addr);
        chk("m_wen", m_wen, e_wen);
        chk("m_wdata", m_wdata, e_wdata);
        chk("i_ready", i_ready, e_iready);
        chk("d_ready", d_ready, e_dready);
        chk("i_rvalid", i_rvalid, mdl_await && mdl_who && m_rvalid);
        chk("d_rvalid", d_rvalid, mdl_await && !mdl_who && m_rvalid);
        chk("i_rdata", i_rdata, m_rdata);
        chk("d_rdata", d_rdata, m_rdata);
        chk("err_rvalid", err_rvalid, mdl_err);
        chk("starve_cnt", 32'(dut.starve_cnt), 32'(mdl_loss));
        if (i_rvalid) n_irv++;
        if (d_rvalid) n_drv++;
        if (i_ready) acc_q.push_back(1'b1);
        if (d_ready) acc_q.push_back(1'b0);
        i_acked = e_iready;
        d_acked = e_dready;

        n_flight = mdl_flight; n_await = mdl_await; n_who = mdl_who;
        n_err = mdl_err; n_loss = mdl_loss;
        if (m_rvalid && !mdl_await) n_err = 1'b1;
        if (mdl_flight && m_ready) begin
            n_flight = 1'b0;
            n_await  = 1'b1;
        end
        free = (!mdl_flight && !mdl_await) || (mdl_await && m_rvalid);
        if (free) begin
            n_await = 1'b0;
            if (i_valid || d_valid) begin
                iw = i_valid && (!d_valid || mdl_loss >= MAX_WAIT);
                n_flight = 1'b1;
                n_who = iw;
                if (iw) n_loss = 0;
                else if (i_valid) n_loss = (mdl_loss + 1 > MAX_WAIT) ? MAX_WAIT : mdl_loss + 1;
            end
        end
        if (rst) begin
            n_flight = 0; n_await = 0; n_who = 0; n_err = 0; n_loss = 0;
        end
        @(posedge clk);
        mdl_flight = n_flight; mdl_await = n_await; mdl_who = n_who;
        mdl_err = n_err; mdl_loss = n_loss;
        #1;
    endtask

    initial begin
        bit exp_pat[10];
        rst = 1'b1;
        i_valid = 0; i_addr = 0; i_wen = 0; i_wdata = 0;
        d_valid = 0; d_addr = 0; d_wen = 0; d_wdata = 0;
        m_ready = 0; m_rvalid = 0; m_rdata = 0;
        mdl_flight = 0; mdl_await = 0; mdl_who = 0; mdl_err = 0; mdl_loss = 0;
        @(posedge clk); #1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Lone instruction fetch
        n_irv = 0; n_drv = 0;
        i_valid = 1; i_addr = 32'h0000_1000;
        tick();
        chk("fetch_m_addr", m_addr, 32'h0000_1000);
        tick(); tick();
        m_ready = 1;
        tick();
        i_valid = 0; m_ready = 0;
        tick(); tick();
        m_rvalid = 1; m_rdata = 32'hDEAD_BEEF;
        #1 chk("fetch_i_rdata", i_rdata, 32'hDEAD_BEEF);
        tick();
        m_rvalid = 0;
        tick();
        chk("fetch_n_irv", n_irv, 1);
        chk("fetch_n_drv", n_drv, 0);

        // Simultaneous requests: data first, instruction right after data's response
        acc_q.delete();
        i_valid = 1; i_addr = 32'h0000_3000;
        d_valid = 1; d_addr = 32'h0000_2000;
        tick();
        chk("simul_first_addr", m_addr, 32'h0000_2000);
        m_ready = 1;
        tick();
        d_valid = 0; m_ready = 0;
        m_rvalid = 1; m_rdata = 32'h0BAD_F00D;
        tick();
        m_rvalid = 0;
        #1;
        chk("simul_i_mvalid", m_valid, 1'b1);
        chk("simul_i_addr", m_addr, 32'h0000_3000);
        m_ready = 1;
        tick();
        i_valid = 0; m_ready = 0; m_rvalid = 1;
        tick();
        m_rvalid = 0;
        tick();
        chk("simul_order_len", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            chk("simul_order_0", acc_q[0], 1'b0);
            chk("simul_order_1", acc_q[1], 1'b1);
        end

        // Starvation: both ports continuously requesting
        acc_q.delete();
        i_valid = 1; d_valid = 1;
        tick();
        for (int k = 0; k < 10; k++) begin
            m_ready = 1;
            tick();
            m_ready = 0; m_rvalid = 1;
            tick();
            m_rvalid = 0;
        end
        i_valid = 0; d_valid = 0; m_ready = 1;
        tick();
        m_ready = 0; m_rvalid = 1;
        tick();
        m_rvalid = 0;
        tick();
        for (int k = 0; k < 10; k++) exp_pat[k] = (k % 5 == 4);
        chk("starve_len", acc_q.size(), 11);
        for (int k = 0; k < 10 && k < acc_q.size(); k++)
            chk($sformatf("starve_grant_%0d", k), acc_q[k], exp_pat[k]);

        // Data write
        n_drv = 0;
        d_valid = 1; d_wen = 1; d_wdata = 32'h1234_5678; d_addr = 32'h0000_0040;
        tick();
        chk("write_m_wen", m_wen, 1'b1);
        chk("write_m_wdata", m_wdata, 32'h1234_5678);
        m_ready = 1;
        tick();
        d_valid = 0; d_wen = 0; m_ready = 0; m_rvalid = 1;
        tick();
        m_rvalid = 0;
        tick(); tick();
        chk("write_n_drv", n_drv, 1);

        // Spurious response in IDLE
        n_irv = 0; n_drv = 0;
        m_rvalid = 1;
        tick();
        m_rvalid = 0;
        tick();
        chk("spur_err", err_rvalid, 1'b1);
        chk("spur_no_rv", n_irv + n_drv, 0);
        d_valid = 1;
        tick();
        m_ready = 1;
        tick();
        d_valid = 0; m_ready = 0;
        tick();
        chk("spur_err_sticky", err_rvalid, 1'b1);

        // Reset while awaiting the response
        rst = 1;
        tick();
        rst = 0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_rvalid, 1'b0);
        chk("rst_mvalid", m_valid, 1'b0);
        tick();
        n_irv = 0;
        i_valid = 1; i_addr = 32'h0000_5000;
        tick();
        m_ready = 1;
        tick();
        i_valid = 0; m_ready = 0; m_rvalid = 1;
        tick();
        m_rvalid = 0;
        tick();
        chk("post_rst_irv", n_irv, 1);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (i_acked) i_valid = 0;
            if (d_acked) d_valid = 0;
            if (!i_valid && $urandom_range(2) == 0) begin
                i_valid = 1; i_addr = $urandom; i_wen = $urandom_range(1); i_wdata = $urandom;
            end
            if (!d_valid && $urandom_range(2) == 0) begin
                d_valid = 1; d_addr = $urandom; d_wen = $urandom_range(1); d_wdata = $urandom;
            end
            m_ready  = $urandom_range(1);
            m_rvalid = mdl_await ? ($urandom_range(9) < 4) : ($urandom_range(49) == 0);
            m_rdata  = $urandom;
            rst      = ($urandom_range(99) == 0);
            tick();
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
